// File: rtl/cicero_fetch_arbiter_if.sv
// Fetch/response bus between the regex cores, the instruction memory and the arbiter.
interface cicero_fetch_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned PC_WIDTH  = 9
);
    logic [NUM_CORES-1:0]          req_valid;
    logic [NUM_CORES*PC_WIDTH-1:0] req_pc;
    logic [NUM_CORES-1:0]          req_ready;
    logic                          mem_rd_en;
    logic [PC_WIDTH-1:0]           mem_addr;
    logic [31:0]                   mem_rdata;
    logic [NUM_CORES-1:0]          rsp_valid;
    logic [NUM_CORES-1:0]          rsp_ready;
    logic [3:0]                    rsp_type;
    logic [15:0]                   rsp_data;
    logic                          rsp_illegal;
    logic                          busy;

    // Arbiter side.
    modport master (
        input  req_valid, req_pc, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_type, rsp_data, rsp_illegal, busy
    );

    // Cores and memory side.
    modport slave (
        output req_valid, req_pc, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_type, rsp_data, rsp_illegal, busy
    );
endinterface

// File: rtl/cicero_fetch_arbiter.sv
// Round-robin instruction-fetch arbiter: shares one single-port instruction
// memory between NUM_CORES regex cores and returns decoded words in grant order.
module cicero_fetch_arbiter #(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned PC_WIDTH      = 9,
    parameter int unsigned CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cicero_fetch_arbiter_if.master bus
);
    localparam int unsigned FIFO_DEPTH = 2;

    typedef struct packed {
        logic [CORE_ID_WIDTH-1:0] owner;
        logic [3:0]               itype;
        logic [15:0]              idata;
        logic                     illegal;
    } rsp_entry_t;

    logic [CORE_ID_WIDTH-1:0] rr_q, rr_d;
    logic                     inflight_q, inflight_d;
    logic [CORE_ID_WIDTH-1:0] tag_q, tag_d;
    logic [PC_WIDTH-1:0]      addr_q, addr_d;
    rsp_entry_t               fifo_q [FIFO_DEPTH];
    rsp_entry_t               fifo_d [FIFO_DEPTH];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               occ_q, occ_d;

    logic                     pop_c;
    logic                     issue_ok_c;
    logic                     grant_vld_c;
    logic [CORE_ID_WIDTH-1:0] grant_idx_c;
    logic [NUM_CORES-1:0]     grant_oh_c;
    logic [PC_WIDTH-1:0]      grant_pc_c;
    logic [NUM_CORES-1:0]     rsp_valid_c;
    rsp_entry_t               head_c;
    rsp_entry_t               push_entry_c;

    // Upper memory word bits carry nothing for the fetch path.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus.mem_rdata[31:20];

    // Head of FIFO decode and pop detection.
    always_comb begin
        head_c      = fifo_q[rd_ptr_q];
        rsp_valid_c = '0;
        if (occ_q != 2'd0) begin
            rsp_valid_c[head_c.owner] = 1'b1;
        end
        pop_c      = |(rsp_valid_c & bus.rsp_ready);
        issue_ok_c = ((3'(occ_q) + 3'(inflight_q)) < 3'd2) || pop_c;
    end

    // Round-robin search starting at the pointer; grants are suppressed while in reset.
    always_comb begin
        logic [CORE_ID_WIDTH-1:0] cand;
        cand        = '0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        grant_oh_c  = '0;
        grant_pc_c  = '0;
        if (rst_n && issue_ok_c) begin
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
                cand = CORE_ID_WIDTH'((32'(rr_q) + k) % NUM_CORES);
                if (!grant_vld_c && bus.req_valid[cand]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = cand;
                end
            end
        end
        if (grant_vld_c) begin
            grant_oh_c[grant_idx_c] = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (grant_idx_c == CORE_ID_WIDTH'(k)) begin
                grant_pc_c = bus.req_pc[k*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    // Next-state: pointer, in-flight stage, held address and response FIFO.
    always_comb begin
        push_entry_c.owner   = tag_q;
        push_entry_c.itype   = bus.mem_rdata[19:16];
        push_entry_c.idata   = bus.mem_rdata[15:0];
        push_entry_c.illegal = (bus.mem_rdata[19:16] >= 4'd10);

        rr_d       = rr_q;
        inflight_d = grant_vld_c;
        tag_d      = tag_q;
        addr_d     = addr_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        if (grant_vld_c) begin
            rr_d   = CORE_ID_WIDTH'((32'(grant_idx_c) + 32'd1) % NUM_CORES);
            tag_d  = grant_idx_c;
            addr_d = grant_pc_c;
        end
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = push_entry_c;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({inflight_q, pop_c})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            addr_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Bus outputs; response fields read as zero when the FIFO is empty.
    assign bus.req_ready   = grant_oh_c;
    assign bus.mem_rd_en   = grant_vld_c;
    assign bus.mem_addr    = addr_d;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_type    = (occ_q != 2'd0) ? head_c.itype : 4'd0;
    assign bus.rsp_data    = (occ_q != 2'd0) ? head_c.idata : 16'd0;
    assign bus.rsp_illegal = (occ_q != 2'd0) && head_c.illegal;
    assign bus.busy        = inflight_q || (occ_q != 2'd0);
endmodule

// File: tb/tb_cicero_fetch_arbiter.sv
// Directed bench for cicero_fetch_arbiter: vector table plus scoreboarded sequences.
module tb_cicero_fetch_arbiter;
    localparam int unsigned NC = 4;
    localparam int unsigned PW = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cicero_fetch_arbiter_if #(.NUM_CORES(NC), .PC_WIDTH(PW)) bus ();
    cicero_fetch_arbiter #(.NUM_CORES(NC), .PC_WIDTH(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Instruction memory with one cycle of read latency.
    logic [31:0] mem [512];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    int n_pass  = 0;
    int n_total = 0;
    int n_rsp   = 0;

    typedef struct {
        int          core;
        logic [3:0]  t;
        logic [15:0] d;
        logic        ill;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [NC-1:0]    req_valid;
        logic [NC*PW-1:0] req_pc;
        logic [NC-1:0]    rsp_ready;
        logic [NC-1:0]    e_rdy;
        logic             e_en;
        logic [PW-1:0]    e_addr;
        logic [NC-1:0]    e_rv;
        logic [3:0]       e_type;
        logic [15:0]      e_data;
        logic             e_ill;
        logic             e_busy;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NC*PW-1:0] pcs(input int p0, input int p1, input int p2, input int p3);
        return {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endfunction

    function automatic vec_t mkv(input logic [NC-1:0] v, input logic [NC*PW-1:0] p, input logic [NC-1:0] r,
                                 input logic [NC-1:0] g, input logic en, input logic [PW-1:0] a,
                                 input logic [NC-1:0] rv, input logic [3:0] t, input logic [15:0] d,
                                 input logic il, input logic b);
        vec_t x;
        x.req_valid = v; x.req_pc = p; x.rsp_ready = r;
        x.e_rdy = g; x.e_en = en; x.e_addr = a; x.e_rv = rv;
        x.e_type = t; x.e_data = d; x.e_ill = il; x.e_busy = b;
        return x;
    endfunction

    task automatic drive(input logic [NC-1:0] v, input logic [NC*PW-1:0] p, input logic [NC-1:0] r);
        bus.req_valid = v;
        bus.req_pc    = p;
        bus.rsp_ready = r;
    endtask

    // One cycle: sample before the edge, check against the scoreboard, then commit.
    task automatic step_sb(input string tag, input logic chk_exp, input logic [NC-1:0] exp_gr,
                           input logic [NC-1:0] exp_rv, output logic [NC-1:0] gr);
        logic [NC-1:0] rv;
        logic          do_pop;
        exp_t          e;
        logic [31:0]   w;
        logic [PW-1:0] pc;
        #3;
        rv = bus.rsp_valid;
        gr = bus.req_ready;
        if (chk_exp) begin
            chk({tag, "_rdy"}, 32'(gr), 32'(exp_gr));
            chk({tag, "_rv"}, 32'(rv), 32'(exp_rv));
        end
        if (rv != '0) begin
            if (sbq.size() == 0) chk({tag, "_spurious"}, 32'(rv), 32'd0);
            else begin
                chk({tag, "_owner"}, 32'(rv), 32'd1 << sbq[0].core);
                chk({tag, "_type"}, 32'(bus.rsp_type), 32'(sbq[0].t));
                chk({tag, "_data"}, 32'(bus.rsp_data), 32'(sbq[0].d));
                chk({tag, "_ill"}, 32'(bus.rsp_illegal), 32'(sbq[0].ill));
            end
        end
        e.core = 0; e.t = '0; e.d = '0; e.ill = 1'b0;
        if (gr != '0) begin
            chk({tag, "_onehot"}, 32'($onehot(gr)), 32'd1);
            for (int c = 0; c < NC; c++) if (gr[c]) e.core = c;
            pc    = bus.req_pc[e.core*PW +: PW];
            w     = mem[pc];
            e.t   = w[19:16];
            e.d   = w[15:0];
            e.ill = (w[19:16] >= 4'd10);
        end
        do_pop = |(rv & bus.rsp_ready);
        @(posedge clk); #1;
        if (do_pop && sbq.size() != 0) begin
            void'(sbq.pop_front());
            n_rsp++;
        end
        if (gr != '0) sbq.push_back(e);
        chk({tag, "_depth"}, 32'(sbq.size() <= 2), 32'd1);
    endtask

    task automatic drain(input string tag);
        logic [NC-1:0] g;
        drive(4'b0000, pcs(0, 0, 0, 0), 4'b1111);
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy && sbq.size() == 0) break;
            step_sb(tag, 1'b0, 4'b0000, 4'b0000, g);
        end
        chk({tag, "_idle"}, 32'({bus.busy, sbq.size() == 0}), 32'b01);
    endtask

    task automatic do_reset();
        drive(4'b0000, pcs(0, 0, 0, 0), 4'b0000);
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] g;
        int            npc [NC];
        int            granted;
        int            rsp0;
        logic [NC-1:0] rr_pat;

        for (int a = 0; a < 512; a++) mem[a] = {12'h5A5, 4'(a % 10), 16'h1000 + 16'(a)};
        mem[5]  = 32'h0002_0041;
        mem[16] = 32'hFFFA_1234;
        mem[62] = 32'h000C_BEEF;

        //            valid    pc                  rrdy     rdy      en    addr     rv       type  data       ill   busy
        vecs[0]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h000, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[1]  = mkv(4'b0100, pcs(0, 0, 5, 0),   4'b1111, 4'b0100, 1'b1, 9'h005, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[2]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b1111, 4'b0000, 1'b0, 9'h005, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b1);
        vecs[3]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0100, 4'b0000, 1'b0, 9'h005, 4'b0100, 4'h2, 16'h0041, 1'b0, 1'b1);
        vecs[4]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h005, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[5]  = mkv(4'b0001, pcs(16, 0, 0, 0),  4'b0000, 4'b0001, 1'b1, 9'h010, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[6]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h010, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b1);
        vecs[7]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h010, 4'b0001, 4'hA, 16'h1234, 1'b1, 1'b1);
        vecs[8]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0010, 4'b0000, 1'b0, 9'h010, 4'b0001, 4'hA, 16'h1234, 1'b1, 1'b1);
        vecs[9]  = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0001, 4'b0000, 1'b0, 9'h010, 4'b0001, 4'hA, 16'h1234, 1'b1, 1'b1);
        vecs[10] = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h010, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[11] = mkv(4'b0100, pcs(0, 0, 7, 0),   4'b1111, 4'b0100, 1'b1, 9'h007, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);
        vecs[12] = mkv(4'b0010, pcs(0, 8, 0, 0),   4'b1111, 4'b0010, 1'b1, 9'h008, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b1);
        vecs[13] = mkv(4'b1010, pcs(0, 9, 0, 3),   4'b1111, 4'b1000, 1'b1, 9'h003, 4'b0100, 4'h7, 16'h1007, 1'b0, 1'b1);
        vecs[14] = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b1111, 4'b0000, 1'b0, 9'h003, 4'b0010, 4'h8, 16'h1008, 1'b0, 1'b1);
        vecs[15] = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b1111, 4'b0000, 1'b0, 9'h003, 4'b1000, 4'h3, 16'h1003, 1'b0, 1'b1);
        vecs[16] = mkv(4'b0000, pcs(0, 0, 0, 0),   4'b0000, 4'b0000, 1'b0, 9'h003, 4'b0000, 4'h0, 16'h0000, 1'b0, 1'b0);

        do_reset();

        // Single fetch, illegal opcode with stall, pointer wrap from 3 to core 1.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req_valid, vecs[i].req_pc, vecs[i].rsp_ready);
            #3;
            chk($sformatf("v%0d_rdy", i),  32'(bus.req_ready),   32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_en", i),   32'(bus.mem_rd_en),   32'(vecs[i].e_en));
            chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d_rv", i),   32'(bus.rsp_valid),   32'(vecs[i].e_rv));
            chk($sformatf("v%0d_type", i), 32'(bus.rsp_type),    32'(vecs[i].e_type));
            chk($sformatf("v%0d_data", i), 32'(bus.rsp_data),    32'(vecs[i].e_data));
            chk($sformatf("v%0d_ill", i),  32'(bus.rsp_illegal), 32'(vecs[i].e_ill));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy),        32'(vecs[i].e_busy));
            @(posedge clk); #1;
        end

        // Fairness: all cores requesting, consumers always ready.
        drive(4'b1111, pcs(20, 21, 22, 23), 4'b1111);
        for (int k = 0; k < 12; k++) begin
            step_sb($sformatf("fair%0d", k), 1'b1, 4'(1 << (k % 4)),
                    (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000, g);
        end
        drain("fair_drain");

        // Backpressure: head owner stalls, FIFO fills, pop frees a slot in the same cycle.
        drive(4'b0001, pcs(30, 0, 0, 0), 4'b0000);  step_sb("bp0", 1'b1, 4'b0001, 4'b0000, g);
        drive(4'b0010, pcs(0, 31, 0, 0), 4'b0000);  step_sb("bp1", 1'b1, 4'b0010, 4'b0000, g);
        drive(4'b0100, pcs(0, 0, 32, 0), 4'b0000);  step_sb("bp2", 1'b1, 4'b0000, 4'b0001, g);
        step_sb("bp3", 1'b1, 4'b0000, 4'b0001, g);
        drive(4'b0100, pcs(0, 0, 32, 0), 4'b0001);  step_sb("bp4", 1'b1, 4'b0100, 4'b0001, g);
        drive(4'b1000, pcs(0, 0, 0, 33), 4'b0000);  step_sb("bp5", 1'b1, 4'b0000, 4'b0010, g);
        step_sb("bp6", 1'b1, 4'b0000, 4'b0010, g);
        drive(4'b1000, pcs(0, 0, 0, 33), 4'b0010);  step_sb("bp7", 1'b1, 4'b1000, 4'b0010, g);
        drain("bp_drain");

        // Asynchronous reset with a read in flight and a queued response.
        drive(4'b0010, pcs(0, 40, 0, 0), 4'b0000);  step_sb("r0", 1'b1, 4'b0010, 4'b0000, g);
        drive(4'b0100, pcs(0, 0, 41, 0), 4'b0000);  step_sb("r1", 1'b1, 4'b0100, 4'b0000, g);
        drive(4'b1111, pcs(44, 45, 46, 47), 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rdy",  32'(bus.req_ready),   32'd0);
        chk("rst_en",   32'(bus.mem_rd_en),   32'd0);
        chk("rst_addr", 32'(bus.mem_addr),    32'd0);
        chk("rst_rv",   32'(bus.rsp_valid),   32'd0);
        chk("rst_type", 32'(bus.rsp_type),    32'd0);
        chk("rst_data", 32'(bus.rsp_data),    32'd0);
        chk("rst_ill",  32'(bus.rsp_illegal), 32'd0);
        chk("rst_busy", 32'(bus.busy),        32'd0);
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        drive(4'b0000, pcs(44, 45, 46, 47), 4'b1111);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        step_sb("p0", 1'b1, 4'b0000, 4'b0000, g);
        drive(4'b1111, pcs(44, 45, 46, 47), 4'b1111);
        step_sb("p1", 1'b1, 4'b0001, 4'b0000, g);
        drive(4'b0000, pcs(44, 45, 46, 47), 4'b1111);
        step_sb("p2", 1'b1, 4'b0000, 4'b0000, g);
        step_sb("p3", 1'b1, 4'b0000, 4'b0001, g);
        drain("rst_drain");

        // Ten back-to-back fetches with periodic stalls to wrap the FIFO pointers.
        for (int c = 0; c < NC; c++) npc[c] = 60 + c;
        granted = 0;
        rsp0    = n_rsp;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (granted == 10 && sbq.size() == 0 && !bus.busy) break;
            rr_pat = (cyc % 3 == 2) ? 4'b0000 : 4'b1111;
            drive((granted < 10) ? 4'b1111 : 4'b0000, pcs(npc[0], npc[1], npc[2], npc[3]), rr_pat);
            step_sb("wrap", 1'b0, 4'b0000, 4'b0000, g);
            for (int c = 0; c < NC; c++) begin
                if (g[c]) begin
                    npc[c] += 4;
                    granted++;
                end
            end
        end
        chk("wrap_grants", 32'(granted), 32'd10);
        chk("wrap_rsps", 32'(n_rsp - rsp0), 32'd10);
        chk("wrap_idle", 32'({bus.busy, sbq.size() == 0}), 32'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
